// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings, opcodes, datapath select encodings and
// the control-word layout for the multicycle MIPS control FSM.
package mips_pkg;
    typedef enum logic [3:0] {
        FETCH, IR_LOAD, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, BEQ, JUMP, ADDI_EXEC, ADDI_WB, TRAP
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       halt;
    } ctrl_t;
    // States whose exit edge completes an instruction.
    function automatic logic is_last(input state_t s);
        return s inside {MEM_WB, MEM_WR, R_WB, BEQ, JUMP, ADDI_WB};
    endfunction
endpackage

// File: rtl/mips_mc_control_if.sv
// mips_mc_if: control bus between the multicycle FSM (master) and the
// datapath / unified memory (slave); opcode flows back from the IR.
interface mips_mc_if;
    logic [5:0] opcode;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    modport master (
        input  opcode,
        output memread, memwrite, iord, irwrite, pcwrite, pcwritecond,
               pcsource, aluop, alusrca, alusrcb, regwrite, regdst, memtoreg
    );
    modport slave (
        output opcode,
        input  memread, memwrite, iord, irwrite, pcwrite, pcwritecond,
               pcsource, aluop, alusrca, alusrcb, regwrite, regdst, memtoreg
    );
endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// mips_mc_ctrl_decode: Moore state -> control-word decode.
// TRAP decodes to halt only when MC_CTRL_TRAP_EN is defined.
module mips_mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH:     ctrl.memread = 1'b1;
            IR_LOAD: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALU_ADD;
                ctrl.pcsource = PC_ALU;
                ctrl.pcwrite = 1'b1;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH;
                ctrl.aluop   = ALU_ADD;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEM_WB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEM_WR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            R_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BEQ: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_RT;
                ctrl.aluop       = ALU_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PC_ALUOUT;
            end
            JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PC_JUMP;
            end
            ADDI_WB:   ctrl.regwrite = 1'b1;
`ifdef MC_CTRL_TRAP_EN
            TRAP:      ctrl.halt = 1'b1;
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: Moore main-control FSM for the multicycle MIPS datapath.
// Optional MC_CTRL_TRAP_EN: unknown opcodes enter a sticky TRAP with halt=1.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    mips_mc_if.master          bus,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   instr_count,
    output logic               halt
);
    state_t state, state_n;
    ctrl_t  ctrl;
    logic   retire;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:     state_n = IR_LOAD;
            IR_LOAD:   state_n = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_n = MEM_ADDR;
                    OP_RTYPE:     state_n = R_EXEC;
                    OP_BEQ:       state_n = BEQ;
                    OP_J:         state_n = JUMP;
                    OP_ADDI:      state_n = ADDI_EXEC;
`ifdef MC_CTRL_TRAP_EN
                    default:      state_n = TRAP;
`else
                    default:      state_n = FETCH;
`endif
                endcase
            end
            MEM_ADDR:  state_n = bus.opcode == OP_LW ? MEM_RD : MEM_WR;
            MEM_RD:    state_n = MEM_WB;
            R_EXEC:    state_n = R_WB;
            ADDI_EXEC: state_n = ADDI_WB;
`ifdef MC_CTRL_TRAP_EN
            TRAP:      state_n = TRAP;
`endif
            default:   state_n = FETCH;
        endcase
    end
    // An unknown opcode leaving DECODE for FETCH retires as a NOP.
    assign retire = is_last(state) || (state == DECODE && state_n == FETCH);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr_count <= '0;
        else if (retire)
            instr_count <= instr_count + 1'b1;
    end
    mips_mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );
    always_comb begin
        bus.memread     = ctrl.memread;
        bus.memwrite    = ctrl.memwrite;
        bus.iord        = ctrl.iord;
        bus.irwrite     = ctrl.irwrite;
        bus.pcwrite     = ctrl.pcwrite;
        bus.pcwritecond = ctrl.pcwritecond;
        bus.pcsource    = ctrl.pcsource;
        bus.aluop       = ctrl.aluop;
        bus.alusrca     = ctrl.alusrca;
        bus.alusrcb     = ctrl.alusrcb;
        bus.regwrite    = ctrl.regwrite;
        bus.regdst      = ctrl.regdst;
        bus.memtoreg    = ctrl.memtoreg;
        halt            = ctrl.halt;
        state_o         = STATE_W'(state);
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: random instruction streams checked every cycle against
// a per-instruction phase-list model, plus directed reset and trap checks.
module tb_mips_mc_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  state_o;
    logic [31:0] instr_count;
    logic        halt;
    logic [17:0] act;
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic [31:0] cnt = 0;

    typedef struct {
        int          st;
        logic [17:0] cw;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    mips_mc_if bus();
    mips_mc_control #(.CNT_W(32), .STATE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state_o     (state_o),
        .instr_count (instr_count),
        .halt        (halt)
    );

    assign act = {bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite,
                  bus.pcwritecond, bus.pcsource, bus.aluop, bus.alusrca,
                  bus.alusrcb, bus.regwrite, bus.regdst, bus.memtoreg, halt};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected outputs of each named phase, straight from the state table.
    // Phases: 0 FETCH 1 IR_LOAD 2 DECODE 3 MEM_ADDR 4 MEM_RD 5 MEM_WB 6 MEM_WR
    // 7 R_EXEC 8 R_WB 9 BEQ 10 JUMP 11 ADDI_EXEC 12 ADDI_WB 13 TRAP
    function automatic logic [17:0] cw(input int s);
        logic mr, mw, io, ir, pw, pc, as, rw, rd, mt, h;
        logic [1:0] ps, ao, bs;
        {mr, mw, io, ir, pw, pc, as, rw, rd, mt, h, ps, ao, bs} = '0;
        case (s)
            0:  mr = 1;
            1:  begin ir = 1; bs = 2'b01; pw = 1; end
            2:  bs = 2'b11;
            3:  begin as = 1; bs = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin mt = 1; rw = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin as = 1; ao = 2'b10; end
            8:  begin rd = 1; rw = 1; end
            9:  begin as = 1; ao = 2'b01; pc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11: begin as = 1; bs = 2'b10; end
            12: rw = 1;
            13: h = 1;
            default: ;
        endcase
        return {mr, mw, io, ir, pw, pc, ps, ao, as, bs, rw, rd, mt, h};
    endfunction

    task automatic push(input logic [5:0] op, output int n);
        int seq[$];
        bit legal;
        legal = 1'b1;
        seq = {0, 1, 2};
        case (op)
            6'b100011: seq = {seq, 3, 4, 5};
            6'b101011: seq = {seq, 3, 6};
            6'b000000: seq = {seq, 7, 8};
            6'b000100: seq = {seq, 9};
            6'b000010: seq = {seq, 10};
            6'b001000: seq = {seq, 11, 12};
            default: begin
                legal = 1'b0;
`ifdef MC_CTRL_TRAP_EN
                repeat (20) seq.push_back(13);
`endif
            end
        endcase
        foreach (seq[i]) q.push_back('{seq[i], cw(seq[i]), cnt});
`ifdef MC_CTRL_TRAP_EN
        if (legal) cnt = cnt + 1;
`else
        cnt = cnt + 1;
`endif
        n = seq.size();
    endtask

    task automatic run(input logic [5:0] op);
        int n;
        bus.opcode = op;
        push(op, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic logic [5:0] pick();
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        int r;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
`ifdef MC_CTRL_TRAP_EN
        r = $urandom_range(0, 5);
`else
        r = $urandom_range(0, 6);
`endif
        if (r < 6) return legal_ops[r];
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        return op;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() == 0) begin
                chk("model_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("state_o", 32'(state_o), 32'(e.st));
                chk("ctrl_word", 32'(act), 32'(e.cw));
                chk("instr_count", instr_count, e.cnt);
                chk("rd_wr_exclusive", 32'(bus.memread & bus.memwrite), 32'd0);
            end
        end
    end

    initial begin
        bus.opcode = 6'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_memread", 32'(bus.memread), 32'd1);
        chk("reset_iord", 32'(bus.iord), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        chk_en = 1'b1;
        run(6'b000000);
        chk("count_after_rtype", instr_count, 32'd1);
        run(6'b100011);
        run(6'b101011);
        run(6'b000100);
        run(6'b000010);
        run(6'b001000);
        chk("count_after_directed", instr_count, 32'd6);
`ifndef MC_CTRL_TRAP_EN
        run(6'b111111);
        chk("count_after_nop", instr_count, 32'd7);
        chk("nop_back_to_fetch", 32'(state_o), 32'd0);
`endif
        repeat (150) run(pick());
        chk("count_after_random", instr_count, cnt);
        chk_en = 1'b0;
        q.delete();
        bus.opcode = 6'b101011;
        repeat (4) @(posedge clk);
        #2;
        chk("sw_in_mem_wr", 32'(state_o), 32'd6);
        chk("sw_memwrite", 32'(bus.memwrite), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_memwrite", 32'(bus.memwrite), 32'd0);
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_count", instr_count, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        chk_en = 1'b1;
        run(6'b000000);
        chk("count_after_rst_recover", instr_count, 32'd1);
`ifdef MC_CTRL_TRAP_EN
        run(6'b111111);
        chk_en = 1'b0;
        chk("trap_halt", 32'(halt), 32'd1);
        chk("trap_state", 32'(state_o), 32'd13);
        chk("trap_count", instr_count, 32'd1);
`endif
        chk_en = 1'b0;
        chk("model_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
